// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between several cores.
// Each access runs IDLE -> ISSUE (-> WAIT for reads); cores that signalled endop are skipped.
module core_mem_arbiter #(
   parameter int core_count = 3,
   parameter int addr_width = 12,
   parameter int data_width = 12
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [core_count-1:0]            req,
   input  logic [core_count-1:0]            we,
   input  logic [core_count*addr_width-1:0] addr,
   input  logic [core_count*data_width-1:0] wdata,
   input  logic [core_count-1:0]            endop,
   output logic [core_count-1:0]            gnt,
   output logic [core_count-1:0]            rvalid,
   output logic [data_width-1:0]            rdata,
   output logic                             mem_en,
   output logic                             mem_we,
   output logic [addr_width-1:0]            mem_addr,
   output logic [data_width-1:0]            mem_wdata,
   input  logic [data_width-1:0]            mem_rdata,
   output logic                             busy,
   output logic                             all_done
);

   localparam int idx_w = (core_count > 1) ? $clog2(core_count) : 1;

   localparam logic [1:0] st_idle  = 2'd0;
   localparam logic [1:0] st_issue = 2'd1;
   localparam logic [1:0] st_wait  = 2'd2;

   localparam logic [idx_w-1:0]      last_rst = idx_w'(core_count - 1);
   localparam logic [core_count-1:0] one_c    = {{(core_count-1){1'b0}}, 1'b1};

   logic [1:0]              state_q, state_d;
   logic [idx_w-1:0]        win_q, win_d;
   logic [idx_w-1:0]        last_q, last_d;
   logic                    wr_q, wr_d;
   logic [addr_width-1:0]   addr_q, addr_d;
   logic [data_width-1:0]   wdata_q, wdata_d;
   logic [core_count-1:0]   done_mask_q, done_mask_d;
   logic [core_count-1:0]   gnt_q, gnt_d;
   logic [core_count-1:0]   rvalid_q, rvalid_d;
   logic [data_width-1:0]   rdata_q, rdata_d;
   logic                    mem_en_q, mem_en_d;
   logic                    mem_we_q, mem_we_d;
   logic [addr_width-1:0]   mem_addr_q, mem_addr_d;
   logic [data_width-1:0]   mem_wdata_q, mem_wdata_d;
   logic                    busy_q, busy_d;
   logic                    all_done_q, all_done_d;

   logic [core_count-1:0]   elig_s;
   logic                    found_s;
   logic [idx_w-1:0]        win_s;

   // Round-robin search starting just after the previous winner, with wrap-around
   always_comb begin
      int               cand;
      logic [idx_w-1:0] cand_idx;
      logic             take;
      elig_s   = req & ~done_mask_q;
      found_s  = 1'b0;
      win_s    = last_q;
      cand     = 0;
      cand_idx = {idx_w{1'b0}};
      take     = 1'b0;
      for (int k = 1; k <= core_count; k++) begin
         cand     = (int'(last_q) + k >= core_count) ? int'(last_q) + k - core_count
                                                     : int'(last_q) + k;
         cand_idx = idx_w'(cand);
         take     = ~found_s & elig_s[cand_idx];
         win_s    = take ? cand_idx : win_s;
         found_s  = found_s | elig_s[cand_idx];
      end
   end

   // Next-state and next-output logic for the access sequencer
   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      last_d      = last_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      gnt_d       = {core_count{1'b0}};
      rvalid_d    = {core_count{1'b0}};
      rdata_d     = rdata_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      // start clears the run's history, but an endop in the same cycle still lands
      done_mask_d = (start ? {core_count{1'b0}} : done_mask_q) | endop;
      case (state_q)
         st_idle: begin
            if (found_s) begin
               win_d   = win_s;
               last_d  = win_s;
               wr_d    = we[win_s];
               addr_d  = addr[int'(win_s)*addr_width +: addr_width];
               wdata_d = wdata[int'(win_s)*data_width +: data_width];
               state_d = st_issue;
            end else begin
               state_d = st_idle;
            end
         end
         st_issue: begin
            mem_en_d    = 1'b1;
            mem_we_d    = wr_q;
            mem_addr_d  = addr_q;
            mem_wdata_d = wdata_q;
            gnt_d       = one_c << win_q;
            state_d     = wr_q ? st_idle : st_wait;
         end
         st_wait: begin
            rdata_d  = mem_rdata;
            rvalid_d = one_c << win_q;
            state_d  = st_idle;
         end
         default: begin
            state_d = st_idle;
         end
      endcase
      busy_d     = (state_d != st_idle);
      all_done_d = &done_mask_d;
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= st_idle;
         win_q       <= {idx_w{1'b0}};
         last_q      <= last_rst;
         wr_q        <= 1'b0;
         addr_q      <= {addr_width{1'b0}};
         wdata_q     <= {data_width{1'b0}};
         done_mask_q <= {core_count{1'b0}};
         gnt_q       <= {core_count{1'b0}};
         rvalid_q    <= {core_count{1'b0}};
         rdata_q     <= {data_width{1'b0}};
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {addr_width{1'b0}};
         mem_wdata_q <= {data_width{1'b0}};
         busy_q      <= 1'b0;
         all_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         last_q      <= last_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         done_mask_q <= done_mask_d;
         gnt_q       <= gnt_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         all_done_q  <= all_done_d;
      end
   end

   assign gnt       = gnt_q;
   assign rvalid    = rvalid_q;
   assign rdata     = rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign all_done  = all_done_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: a table of isolated accesses, hand-written corner sequences,
// and a random phase, all checked every cycle against a transaction-timeline reference model.
module tb_core_mem_arbiter;

   localparam int NC = 3;
   localparam int AW = 12;
   localparam int DW = 12;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [NC-1:0]     req, we, endop;
   logic [NC*AW-1:0]  addr;
   logic [NC*DW-1:0]  wdata;
   logic [NC-1:0]     gnt, rvalid;
   logic [DW-1:0]     rdata, mem_wdata, mem_rdata;
   logic [AW-1:0]     mem_addr;
   logic              mem_en, mem_we, busy, all_done;

   core_mem_arbiter #(.core_count(NC), .addr_width(AW), .data_width(DW)) dut (
      .clk(clk), .reset(rst), .start(start), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .endop(endop), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .all_done(all_done)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] pat(input int i);
      return (i == 5) ? 12'hABC : 12'((i * 37 + 161) & 4095);
   endfunction

   function automatic logic [2:0] oh(input int i);
      return 3'b001 << i;
   endfunction

   // Memory: read data follows the presented address; writes land on the clock edge
   logic [DW-1:0] mem [0:255];
   logic          mem_ready = 1'b0;
   assign mem_rdata = mem[mem_addr[7:0]];
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= pat(i);
         mem_ready <= 1'b1;
      end else if (mem_en && mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
   end

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model: arbitration edges, expected ack edges and expected memory contents
   logic [2:0]  m_done;
   int          m_last, m_next_arb, m_arb_e, m_w, g_edge, r_edge;
   logic        m_we, exp_all_done;
   logic [11:0] m_addr, m_wdata, m_rval, exp_rdata;
   logic [11:0] ref_mem [0:255];
   logic [2:0]  hold_req;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_done = 3'b000; m_last = NC - 1; m_next_arb = 0; m_arb_e = -100;
      m_w = 0; g_edge = -1; r_edge = -1; m_we = 1'b0;
      exp_rdata = 12'h000; exp_all_done = 1'b0;
   endtask

   task automatic check_all();
      chk("gnt", {29'd0, gnt}, {29'd0, (cyc == g_edge) ? oh(m_w) : 3'b000});
      chk("rvalid", {29'd0, rvalid}, {29'd0, (cyc == r_edge) ? oh(m_w) : 3'b000});
      chk("rdata", {20'd0, rdata}, {20'd0, exp_rdata});
      chk("mem_en", {31'd0, mem_en}, {31'd0, cyc == g_edge});
      if (cyc == g_edge) begin
         chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
         chk("mem_addr", {20'd0, mem_addr}, {20'd0, m_addr});
         if (m_we) chk("mem_wdata", {20'd0, mem_wdata}, {20'd0, m_wdata});
      end
      chk("busy", {31'd0, busy}, {31'd0, (cyc == m_arb_e) || (!m_we && cyc == m_arb_e + 1)});
      chk("all_done", {31'd0, all_done}, {31'd0, exp_all_done});
   endtask

   // One clock: predict the arbitration at the coming edge, then check and play the cores
   task automatic tick();
      int         e;
      logic [2:0] elig;
      e = cyc + 1;
      if (rst) begin
         model_reset();
      end else begin
         elig = req & ~m_done;
         if (e >= m_next_arb && elig != 3'b000) begin
            m_w = -1;
            for (int k = 1; k <= NC; k++)
               if (m_w < 0 && elig[(m_last + k) % NC]) m_w = (m_last + k) % NC;
            m_last  = m_w;
            m_we    = we[m_w];
            m_addr  = addr[m_w*AW +: AW];
            m_wdata = wdata[m_w*DW +: DW];
            m_arb_e = e;
            g_edge  = e + 1;
            if (m_we) begin
               ref_mem[m_addr[7:0]] = m_wdata;
               r_edge = -1; m_next_arb = e + 2;
            end else begin
               m_rval = ref_mem[m_addr[7:0]];
               r_edge = e + 2; m_next_arb = e + 3;
            end
         end
         m_done = (start ? 3'b000 : m_done) | endop;
         exp_all_done = &m_done;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == r_edge) exp_rdata = m_rval;
      check_all();
      if (cyc == g_edge && m_we) req[m_w] = 1'b0;
      if (cyc == r_edge) req[m_w] = 1'b0;
      endop = 3'b000;
      start = 1'b0;
      req   = req | hold_req;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      int          core;
      logic        wr;
      logic [11:0] a;
      logic [11:0] d;
      logic [2:0]  g;
      logic [11:0] r;
   } vec_t;

   initial begin
      vec_t vecs [6];
      int   c;
      vecs[0] = '{1, 1'b0, 12'h005, 12'h000, 3'b010, 12'hABC};
      vecs[1] = '{2, 1'b1, 12'h00F, 12'h123, 3'b100, 12'h000};
      vecs[2] = '{2, 1'b0, 12'h00F, 12'h000, 3'b100, 12'h123};
      vecs[3] = '{0, 1'b1, 12'h020, 12'h7FF, 3'b001, 12'h000};
      vecs[4] = '{0, 1'b0, 12'h020, 12'h000, 3'b001, 12'h7FF};
      vecs[5] = '{1, 1'b0, 12'h000, 12'h000, 3'b010, 12'h0A1};

      for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
      rst = 1'b1; start = 1'b0; req = 3'b000; we = 3'b000; endop = 3'b000;
      addr = '0; wdata = '0; hold_req = 3'b000;
      model_reset();
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Isolated accesses: grant two cycles after req, read data one cycle after grant
      for (int v = 0; v < 6; v++) begin
         c = vecs[v].core;
         we[c] = vecs[v].wr;
         addr[c*AW +: AW]  = vecs[v].a;
         wdata[c*DW +: DW] = vecs[v].d;
         req[c] = 1'b1;
         tick(); tick();
         chk("vec_gnt", {29'd0, gnt}, {29'd0, vecs[v].g});
         chk("vec_mem_we", {31'd0, mem_we}, {31'd0, vecs[v].wr});
         chk("vec_mem_addr", {20'd0, mem_addr}, {20'd0, vecs[v].a});
         if (vecs[v].wr) begin
            chk("vec_mem_wdata", {20'd0, mem_wdata}, {20'd0, vecs[v].d});
         end else begin
            tick();
            chk("vec_rvalid", {29'd0, rvalid}, {29'd0, vecs[v].g});
            chk("vec_rdata", {20'd0, rdata}, {20'd0, vecs[v].r});
         end
         tick();
      end

      // Reset in the middle of a read's ISSUE cycle
      we = 3'b000;
      addr[1*AW +: AW] = 12'h005; addr[2*AW +: AW] = 12'h00F;
      req[1] = 1'b1; req[2] = 1'b1;
      tick();
      rst = 1'b1;
      #1;
      chk("rst_gnt", {29'd0, gnt}, 32'd0);
      chk("rst_rvalid", {29'd0, rvalid}, 32'd0);
      chk("rst_rdata", {20'd0, rdata}, 32'd0);
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      model_reset();
      tick(); tick();
      rst = 1'b0;
      addr[0*AW +: AW] = 12'h010;
      req[0] = 1'b1;
      tick(); tick();
      chk("rst_first_gnt", {29'd0, gnt}, 32'd1);
      repeat (12) tick();

      // Contention: continuous reads from all cores, grants rotate every 3 cycles
      pulse_reset();
      addr[0*AW +: AW] = 12'h001; addr[1*AW +: AW] = 12'h002; addr[2*AW +: AW] = 12'h003;
      hold_req = 3'b111; req = 3'b111;
      tick();
      for (int g = 0; g < 6; g++) begin
         tick();
         chk("rr_order", {29'd0, gnt}, {29'd0, oh(g % 3)});
         tick(); tick();
      end
      hold_req = 3'b000;
      repeat (12) tick();

      // endop for core1 while its read is in WAIT
      pulse_reset();
      hold_req = 3'b111; req = 3'b111;
      tick(); tick();
      chk("mask_g0", {29'd0, gnt}, 32'd1);
      tick(); tick(); tick();
      chk("mask_g1", {29'd0, gnt}, 32'd2);
      endop = 3'b010;
      tick();
      chk("mask_rvalid1", {29'd0, rvalid}, 32'd2);
      tick(); tick();
      chk("mask_g2", {29'd0, gnt}, 32'd4);
      tick(); tick(); tick();
      chk("mask_g0b", {29'd0, gnt}, 32'd1);
      tick(); tick(); tick();
      chk("mask_skip1", {29'd0, gnt}, 32'd4);
      hold_req = 3'b000;
      req[1] = 1'b0;
      repeat (10) tick();

      // Completion, idling with everything done, and restart
      pulse_reset();
      endop = 3'b001; tick();
      endop = 3'b100; tick();
      chk("done_partial", {31'd0, all_done}, 32'd0);
      endop = 3'b010; tick();
      chk("done_all", {31'd0, all_done}, 32'd1);
      chk("done_busy", {31'd0, busy}, 32'd0);
      we[0] = 1'b0; addr[0*AW +: AW] = 12'h007; req[0] = 1'b1;
      tick(); tick(); tick();
      chk("done_ignored", {29'd0, gnt}, 32'd0);
      chk("done_idle", {31'd0, busy}, 32'd0);
      start = 1'b1;
      tick();
      chk("restart_clr", {31'd0, all_done}, 32'd0);
      tick(); tick();
      chk("restart_gnt", {29'd0, gnt}, 32'd1);
      repeat (4) tick();

      // Random traffic with occasional endop and start
      for (int n = 0; n < 2000; n++) begin
         for (int i = 0; i < NC; i++) begin
            if (!req[i] && $urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
               we[i]  = 1'($urandom_range(0, 1));
               addr[i*AW +: AW]  = 12'($urandom_range(0, 15));
               wdata[i*DW +: DW] = 12'($urandom);
            end
            if ($urandom_range(0, 79) == 0) endop[i] = 1'b1;
         end
         if ($urandom_range(0, 59) == 0) start = 1'b1;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
